// File: rtl/elevator_request_scheduler_if.sv
// Request/target bus between the floor-button panel, the scheduler and the
// car controller. The scheduler sits on the slave side; the driver of buttons,
// car position and door status sits on the master side.
interface elevator_request_scheduler_if;
  logic [15:0] btn_press;
  logic        emergency;
  logic [3:0]  current_floor;
  logic        door_status;
  logic [3:0]  floor_request;
  logic [15:0] pending;
  logic [4:0]  pending_count;
  logic        sweep_up;
  logic        dwell;

  modport master (
    output btn_press, emergency, current_floor, door_status,
    input  floor_request, pending, pending_count, sweep_up, dwell
  );

  modport slave (
    input  btn_press, emergency, current_floor, door_status,
    output floor_request, pending, pending_count, sweep_up, dwell
  );
endinterface

// File: rtl/elevator_request_scheduler.sv
// SCAN-policy request scheduler for a 16-floor car. Latches button presses
// into a pending set, sweeps in one direction until nothing is left ahead,
// then reverses. Arrival (door open at a pending floor) clears that floor and
// holds the target there for DWELL_CYCLES cycles.
module elevator_request_scheduler #(
  parameter int unsigned DWELL_CYCLES = 8
) (
  input logic                         clk,
  input logic                         reset,
  elevator_request_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE_UP, SERVE_DOWN, DWELL} state_t;

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  floor_request_q, floor_request_d;
  logic [15:0] pending_q, pending_d;
  logic        sweep_up_q, sweep_up_d;
  logic [7:0]  dwell_cnt_q, dwell_cnt_d;

  logic [3:0]  lowest_above, highest_below;
  logic        any_above, any_below;
  logic [3:0]  dist_up, dist_down;
  logic        go_up;
  logic        arrival;
  logic [15:0] clear_mask, press_eff;
  logic [4:0]  count;

  // Door open at a floor we owe a stop; ignored while already dwelling.
  assign arrival    = bus.door_status && pending_q[bus.current_floor] && (state_q != DWELL);
  assign clear_mask = arrival ? (16'd1 << bus.current_floor) : 16'd0;

  // Presses for the current floor are dropped while the door is already open.
  assign press_eff = (state_q == DWELL) ? (bus.btn_press & ~(16'd1 << bus.current_floor))
                                        : bus.btn_press;

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    lowest_above  = '0;
    highest_below = '0;
    any_above     = 1'b0;
    any_below     = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (pending_q[i] && (4'(i) > bus.current_floor)) begin
        lowest_above = 4'(i);
        any_above    = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (pending_q[i] && (4'(i) < bus.current_floor)) begin
        highest_below = 4'(i);
        any_below     = 1'b1;
      end
    end
  end

  // Distances are taken in the non-wrapping order, so 4 bits suffice.
  assign dist_up   = lowest_above - bus.current_floor;
  assign dist_down = bus.current_floor - highest_below;
  assign go_up     = any_above && (!any_below || (dist_up <= dist_down));

  // Popcount of the registered pending set.
  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) count = count + 5'(pending_q[i]);
  end

  // Next-state, next-target and pending-set update.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d         = state_q;
    floor_request_d = floor_request_q;
    sweep_up_d      = sweep_up_q;
    dwell_cnt_d     = dwell_cnt_q;
    pending_d       = (pending_q | press_eff) & ~clear_mask;

    if (bus.emergency) begin
      pending_d       = '0;
      state_d         = IDLE;
      floor_request_d = bus.current_floor;
      dwell_cnt_d     = '0;
    end else if (arrival) begin
      state_d         = DWELL;
      dwell_cnt_d     = DWELL_LOAD;
      floor_request_d = bus.current_floor;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pending_q == '0 || pending_q[bus.current_floor]) begin
            floor_request_d = bus.current_floor;
          end else if (go_up) begin
            state_d         = SERVE_UP;
            sweep_up_d      = 1'b1;
            floor_request_d = lowest_above;
          end else begin
            state_d         = SERVE_DOWN;
            sweep_up_d      = 1'b0;
            floor_request_d = highest_below;
          end
        end
        SERVE_UP: begin
          if (any_above) begin
            floor_request_d = lowest_above;
          end else if (any_below) begin
            state_d         = SERVE_DOWN;
            sweep_up_d      = 1'b0;
            floor_request_d = highest_below;
          end else begin
            state_d         = IDLE;
            floor_request_d = bus.current_floor;
          end
        end
        SERVE_DOWN: begin
          if (any_below) begin
            floor_request_d = highest_below;
          end else if (any_above) begin
            state_d         = SERVE_UP;
            sweep_up_d      = 1'b1;
            floor_request_d = lowest_above;
          end else begin
            state_d         = IDLE;
            floor_request_d = bus.current_floor;
          end
        end
        DWELL: begin
          floor_request_d = bus.current_floor;
          if (dwell_cnt_q != '0) begin
            dwell_cnt_d = dwell_cnt_q - 8'd1;
          end else if (sweep_up_q && any_above) begin
            state_d         = SERVE_UP;
            floor_request_d = lowest_above;
          end else if (!sweep_up_q && any_below) begin
            state_d         = SERVE_DOWN;
            floor_request_d = highest_below;
          end else if (any_above) begin
            state_d         = SERVE_UP;
            sweep_up_d      = 1'b1;
            floor_request_d = lowest_above;
          end else if (any_below) begin
            state_d         = SERVE_DOWN;
            sweep_up_d      = 1'b0;
            floor_request_d = highest_below;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, target, direction, dwell counter and pending-set registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      floor_request_q <= '0;
      pending_q       <= '0;
      sweep_up_q      <= 1'b1;
      dwell_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state_q         <= state_d;
      floor_request_q <= floor_request_d;
      pending_q       <= pending_d;
      sweep_up_q      <= sweep_up_d;
      dwell_cnt_q     <= dwell_cnt_d;
    end
  end

  assign bus.floor_request = floor_request_q;
  assign bus.pending       = pending_q;
  assign bus.pending_count = count;
  assign bus.sweep_up      = sweep_up_q;
  assign bus.dwell         = (state_q == DWELL);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler: SCAN retargeting, tie-break,
// dwell length, in-dwell press discard, emergency flush and async reset.
module tb_elevator_request_scheduler;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_dwell;

  elevator_request_scheduler_if bus ();

  elevator_request_scheduler #(.DWELL_CYCLES(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts cycles with dwell high, starting from the current one; bounded.
  task automatic run_dwell(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.dwell) break;
      n++;
      step();
    end
  endtask

  task automatic press(input logic [15:0] mask);
    bus.btn_press = mask;
    step();
    bus.btn_press = '0;
  endtask

  task automatic arrive(input logic [3:0] floor);
    bus.current_floor = floor;
    bus.door_status   = 1'b1;
    step();
    bus.door_status   = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.btn_press     = '0;
    bus.emergency     = 1'b0;
    bus.current_floor = 4'd0;
    bus.door_status   = 1'b0;
    step();
    step();
    check("rst_floor_request", 32'(bus.floor_request), 32'd0);
    check("rst_pending",       32'(bus.pending),       32'd0);
    check("rst_count",         32'(bus.pending_count), 32'd0);
    check("rst_sweep_up",      32'(bus.sweep_up),      32'd1);
    check("rst_dwell",         32'(bus.dwell),         32'd0);
    reset = 1'b0;
    step();

    // Idle at 0, press 5: pending at the press edge, target one edge later.
    press(16'h0020);
    check("t1_pending",       32'(bus.pending),       32'h0020);
    check("t1_count",         32'(bus.pending_count), 32'd1);
    check("t1_target_early",  32'(bus.floor_request), 32'd0);
    step();
    check("t1_target",        32'(bus.floor_request), 32'd5);
    arrive(4'd5);
    check("t1_arr_pending",   32'(bus.pending),       32'h0000);
    check("t1_arr_dwell",     32'(bus.dwell),         32'd1);
    run_dwell(n_dwell);
    check("t1_dwell_len",     32'(n_dwell),           32'd8);
    check("t1_after_target",  32'(bus.floor_request), 32'd5);

    // Sweep up to 9 from 4, then press 6 and 2 mid-travel.
    bus.current_floor = 4'd4;
    step();
    press(16'h0200);
    step();
    check("t2_target9",       32'(bus.floor_request), 32'd9);
    check("t2_sweep_up",      32'(bus.sweep_up),      32'd1);
    press(16'h0044);
    check("t2_pending",       32'(bus.pending),       32'h0244);
    check("t2_count",         32'(bus.pending_count), 32'd3);
    step();
    check("t2_retarget6",     32'(bus.floor_request), 32'd6);
    arrive(4'd6);
    check("t2_pending_at6",   32'(bus.pending),       32'h0204);
    run_dwell(n_dwell);
    check("t2_dwell6_len",    32'(n_dwell),           32'd8);
    check("t2_target9_again", 32'(bus.floor_request), 32'd9);
    check("t2_sweep_still_up",32'(bus.sweep_up),      32'd1);
    arrive(4'd9);
    run_dwell(n_dwell);
    check("t2_reverse_target",32'(bus.floor_request), 32'd2);
    check("t2_sweep_down",    32'(bus.sweep_up),      32'd0);
    check("t2_pending_2",     32'(bus.pending),       32'h0004);
    arrive(4'd2);
    run_dwell(n_dwell);
    check("t2_idle_target",   32'(bus.floor_request), 32'd2);

    // Idle at 8, presses at 5 and 11: equal distance, upward wins.
    bus.current_floor = 4'd8;
    step();
    press(16'h0820);
    step();
    check("t3_tie_target",    32'(bus.floor_request), 32'd11);
    check("t3_tie_sweep",     32'(bus.sweep_up),      32'd1);
    arrive(4'd11);
    run_dwell(n_dwell);
    check("t3_then_5",        32'(bus.floor_request), 32'd5);
    check("t3_then_down",     32'(bus.sweep_up),      32'd0);
    arrive(4'd5);
    run_dwell(n_dwell);

    // Dwell at 3; a press for 3 during dwell is discarded.
    bus.current_floor = 4'd3;
    step();
    press(16'h0008);
    check("t4_pending3",      32'(bus.pending),       32'h0008);
    step();
    check("t4_in_place",      32'(bus.floor_request), 32'd3);
    arrive(4'd3);
    check("t4_dwell",         32'(bus.dwell),         32'd1);
    press(16'h0008);
    check("t4_discarded",     32'(bus.pending),       32'h0000);
    run_dwell(n_dwell);
    check("t4_dwell_rest",    32'(n_dwell),           32'd7);
    press(16'h0008);
    check("t4_repress",       32'(bus.pending),       32'h0008);
    step();
    check("t4_retarget3",     32'(bus.floor_request), 32'd3);
    arrive(4'd3);
    check("t4_second_clear",  32'(bus.pending),       32'h0000);
    run_dwell(n_dwell);
    check("t4_second_dwell",  32'(n_dwell),           32'd8);

    // Pending {1,7,12}, then emergency flushes and blocks presses.
    press(16'h1082);
    check("t5_pending",       32'(bus.pending),       32'h1082);
    check("t5_count",         32'(bus.pending_count), 32'd3);
    step();
    check("t5_nearest_down",  32'(bus.floor_request), 32'd1);
    bus.current_floor = 4'd2;
    bus.emergency     = 1'b1;
    bus.btn_press     = 16'h0200;
    step();
    check("t5_em_pending",    32'(bus.pending),       32'h0000);
    check("t5_em_count",      32'(bus.pending_count), 32'd0);
    check("t5_em_target",     32'(bus.floor_request), 32'd2);
    check("t5_em_dwell",      32'(bus.dwell),         32'd0);
    step();
    check("t5_em_ignore",     32'(bus.pending),       32'h0000);
    bus.emergency = 1'b0;
    bus.btn_press = '0;
    step();
    check("t5_release",       32'(bus.floor_request), 32'd2);

    // Mid-dwell at 5 with {2,14} still pending, async reset between edges.
    bus.current_floor = 4'd5;
    step();
    press(16'h4024);
    step();
    arrive(4'd5);
    check("t6_pre_pending",   32'(bus.pending),       32'h4004);
    check("t6_pre_count",     32'(bus.pending_count), 32'd2);
    check("t6_pre_dwell",     32'(bus.dwell),         32'd1);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_target",    32'(bus.floor_request), 32'd0);
    check("t6_rst_pending",   32'(bus.pending),       32'd0);
    check("t6_rst_count",     32'(bus.pending_count), 32'd0);
    check("t6_rst_sweep",     32'(bus.sweep_up),      32'd1);
    check("t6_rst_dwell",     32'(bus.dwell),         32'd0);
    step();
    reset = 1'b0;
    step();
    check("t6_post_pending",  32'(bus.pending),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
